uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port prescale  in  16  baud divisor; bit period = max(prescale,1)*8 clk cycles.
REQ-005 SHALL have port wr_data  in  8  byte to enqueue.
REQ-006 SHALL have port wr_en  in  1  single-cycle push strobe, one per bus write to UART DATA.
REQ-007 SHALL have port ovf_clr  in  1  clears the overflow flag.
REQ-008 SHALL have port txd  out  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  out  1  frame in progress.
REQ-010 SHALL have port empty  out  1  FIFO holds zero bytes.
REQ-011 SHALL have port full  out  1  FIFO holds DEPTH bytes.
REQ-012 SHALL have port level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port ovf  out  1  sticky flag, set when a push is dropped.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly one bit period.
REQ-015 Push SHALL be accepted at a wr_en edge only when full=0 at that edge; level increments the same edge.
REQ-016 wr_en with full=1 SHALL drop the byte and set ovf, even when a pop occurs on the same edge.
REQ-017 ovf SHALL stay set until ovf_clr=1; if ovf_clr and a dropped push coincide, ovf SHALL end set.
REQ-018 Serializer FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE->START SHALL occur on the first edge with empty=0; that edge pops the head byte into the shift register and latches prescale.
REQ-020 Latency SHALL be: wr_en at edge N into an empty FIFO with IDLE -> txd=0 from edge N+1.
REQ-021 START->DATA SHALL follow one bit period.
REQ-022 DATA->STOP SHALL follow 8 bit periods, counted by a 3-bit counter.
REQ-023 At end of STOP, with empty=0, the FSM SHALL pop and enter START on that edge (no idle gap).
REQ-024 At end of STOP, with empty=1, the FSM SHALL return to IDLE.
REQ-025 prescale changes mid-frame SHALL not affect the current frame.
REQ-026 tx_busy SHALL be 1 in START, DATA and STOP, and 0 only in IDLE.
REQ-027 Simultaneous push and pop SHALL leave level unchanged (when not full).
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The baud counter SHALL be 19 bits, loaded with max(prescale,1)*8-1 and counting down to 0 to mark each bit boundary.

Reset
REQ-030 On rst=0, independent of clk: txd=1, tx_busy=0, state IDLE, empty=1, full=0, level=0, ovf=0, pointers and counters 0.
REQ-031 Reset mid-frame SHALL force txd high immediately and discard all queued bytes.
REQ-032 After reset release, the first push SHALL behave per REQ-020.

Structure
REQ-033 Shared package uart_pkg SHALL hold DATA_W=8, BAUD_OVERSAMPLE=8 and the FSM state enum.
REQ-034 The FIFO SHALL be a sub-module uart_fifo (push/pop/full/empty/level); the FSM and baud counter live in uart_tx_buf.

Verification
REQ-035 Scenario: prescale=1, push 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each held 8 cycles; tx_busy high for 80 cycles.
REQ-036 Scenario: prescale=2, push 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back (160 cycles each), no idle gap; empty=1 after the second pop.
REQ-037 Scenario: serializer busy, push 9 bytes with DEPTH=8 -> after the first pop, 8 accepted; then full=1; ninth byte dropped, ovf=1; ovf_clr pulse -> ovf=0.
REQ-038 Scenario: full=1, pop and wr_en on the same edge -> push dropped, ovf=1, level=7.
REQ-039 Scenario: prescale changed 1->4 mid-frame -> current frame keeps 8-cycle bits; next frame uses 32-cycle bits.
REQ-040 Scenario: rst=0 during DATA bit 4 -> txd=1 within the same cycle; level=0 and tx_busy=0 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: data width,
// baud oversampling factor, serializer state encoding and the helper
// that turns a prescale value into a baud-counter reload value.
package uart_pkg;

    localparam int DATA_W          = 8;
    localparam int BAUD_OVERSAMPLE = 8;
    localparam int BAUD_W          = 19;
    localparam int PRESCALE_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Reload value for one bit period: max(prescale,1)*8 - 1, so the counter
    // spends exactly one bit period counting down to zero.
    function automatic logic [BAUD_W-1:0] baud_reload(input logic [PRESCALE_W-1:0] prescale);
        logic [BAUD_W-1:0] p;
        p = (prescale == '0) ? BAUD_W'(1) : BAUD_W'(prescale);
        return p * BAUD_W'(BAUD_OVERSAMPLE) - BAUD_W'(1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the serializer. The head byte is presented
// combinationally so the serializer can load it on the same edge it pops.
// Pointers are AW bits wide and wrap naturally because DEPTH is a power of two.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push, do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push and pop together leave level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control state; reset discards every queued byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a byte FIFO in front of a
// START/DATA/STOP serializer. The bit period is latched when a byte is
// popped, so prescale changes only take effect on the next frame.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PRESCALE_W-1:0]      prescale,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en,
    input  logic                       ovf_clr,
    output logic                       txd,
    output logic                       tx_busy,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf
);

    tx_state_t          state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BAUD_W-1:0]  baud_load_q, baud_load_d;
    logic               ovf_q, ovf_d;
    logic               pop;
    logic               baud_done;
    logic [BAUD_W-1:0]  reload_now;
    logic [DATA_W-1:0]  head_data;

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign baud_done  = (baud_cnt_q == '0);
    assign reload_now = baud_reload(prescale);

    // Line level is decoded from registered state, so reset drives it high at once.
    assign txd     = (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[0] : 1'b1;
    assign tx_busy = (state_q != IDLE);
    assign ovf     = ovf_q;

    // Serializer next-state: pop and latch the bit period whenever a frame starts.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_cnt_d  = baud_cnt_q;
        baud_load_d = baud_load_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_d     = head_data;
                    baud_load_d = reload_now;
                    baud_cnt_d  = reload_now;
                    state_d     = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = baud_load_q;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = baud_load_q;
                    if (bit_cnt_q == 3'(DATA_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        shift_d     = head_data;
                        baud_load_d = reload_now;
                        baud_cnt_d  = reload_now;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow is sticky; a dropped push wins over a simultaneous clear.
    always_comb begin
        ovf_d = (ovf_q & ~ovf_clr) | (wr_en & full);
    end

    // Serializer and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            baud_cnt_q  <= '0;
            baud_load_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_cnt_q  <= baud_cnt_d;
            baud_load_q <= baud_load_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: single frame, back-to-back frames,
// overflow handling, reset mid-frame and prescale changes.
module tb_uart_tx_buf;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   prescale = 16'd1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          txd;
    logic          tx_busy;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int frame_start;

    uart_tx_buf #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .ovf_clr  (ovf_clr),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    // Called while the START bit of a frame is already on the line; walks the
    // whole frame cycle by cycle.
    task automatic expect_frame(input string name, input logic [7:0] data, input int len);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < len; c++) begin
                if (i != 0 || c != 0) step();
                n_cmp++;
                if (txd !== frame[i]) begin
                    n_bad++;
                    $display("FAIL %s txd bit %0d cyc %0d: got %0b expected %0b", name, i, c, txd, frame[i]);
                end
                n_cmp++;
                if (tx_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s tx_busy bit %0d cyc %0d: got %0b expected 1", name, i, c, tx_busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL reset txd: got %0b expected 1", txd); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset tx_busy: got %0b expected 0", tx_busy); end
        n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL reset empty: got %0b expected 1", empty); end
        n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL reset full: got %0b expected 0", full); end
        n_cmp++; if (level !== 4'd0)   begin n_bad++; $display("FAIL reset level: got %0d expected 0", level); end
        n_cmp++; if (ovf !== 1'b0)     begin n_bad++; $display("FAIL reset ovf: got %0b expected 0", ovf); end
        step();
        step();
        rst = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        prescale = 16'd1;
        push_byte(8'h55);
        n_cmp++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL single push-edge txd: got %0b expected 1", txd); end
        n_cmp++; if (level !== 4'd1)   begin n_bad++; $display("FAIL single push-edge level: got %0d expected 1", level); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL single push-edge tx_busy: got %0b expected 0", tx_busy); end
        step();
        n_cmp++; if (level !== 4'd0)   begin n_bad++; $display("FAIL single pop level: got %0d expected 0", level); end
        expect_frame("frame55", 8'h55, 8);
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL single end tx_busy: got %0b expected 0", tx_busy); end
        n_cmp++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL single end txd: got %0b expected 1", txd); end
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back();
        prescale = 16'd2;
        push_byte(8'hA3);
        push_byte(8'h0F);
        n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL b2b push+pop level: got %0d expected 1", level); end
        expect_frame("frameA3", 8'hA3, 16);
        step();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b second pop empty: got %0b expected 1", empty); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL b2b second pop level: got %0d expected 0", level); end
        expect_frame("frame0F", 8'h0F, 16);
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL b2b end tx_busy: got %0b expected 0", tx_busy); end
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        prescale = 16'd1;
        push_byte(8'hE7);
        push_byte(8'h01);
        frame_start = cyc;
        for (int i = 2; i <= 8; i++) push_byte(8'(i));
        n_cmp++; if (full !== 1'b1)  begin n_bad++; $display("FAIL ovf full after 8: got %0b expected 1", full); end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf level after 8: got %0d expected 8", level); end
        n_cmp++; if (ovf !== 1'b0)   begin n_bad++; $display("FAIL ovf flag after 8: got %0b expected 0", ovf); end
        push_byte(8'h99);
        n_cmp++; if (ovf !== 1'b1)   begin n_bad++; $display("FAIL ovf flag after 9th: got %0b expected 1", ovf); end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf level after 9th: got %0d expected 8", level); end
        ovf_clr = 1'b1;
        push_byte(8'hAA);
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b1)   begin n_bad++; $display("FAIL ovf clear+drop: got %0b expected 1", ovf); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0)   begin n_bad++; $display("FAIL ovf after clear: got %0b expected 0", ovf); end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf level after clear: got %0d expected 8", level); end
        // Last STOP cycle of the 0xE7 frame; the next edge pops while full.
        while (cyc < frame_start + 79) step();
        push_byte(8'hBB);
        n_cmp++; if (level !== 4'd7) begin n_bad++; $display("FAIL full pop+push level: got %0d expected 7", level); end
        n_cmp++; if (ovf !== 1'b1)   begin n_bad++; $display("FAIL full pop+push ovf: got %0b expected 1", ovf); end
        n_cmp++; if (full !== 1'b0)  begin n_bad++; $display("FAIL full pop+push full: got %0b expected 0", full); end
        n_cmp++; if (txd !== 1'b0)   begin n_bad++; $display("FAIL full pop+push start txd: got %0b expected 0", txd); end
        frame_start = cyc;
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid_frame();
        // Frame of 0x01 in progress; move into data bit 4 (a zero).
        while (cyc < frame_start + 5 * 8 + 3) step();
        n_cmp++; if (txd !== 1'b0)     begin n_bad++; $display("FAIL midrst pre txd: got %0b expected 0", txd); end
        n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL midrst pre tx_busy: got %0b expected 1", tx_busy); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL midrst txd: got %0b expected 1", txd); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst tx_busy: got %0b expected 0", tx_busy); end
        n_cmp++; if (level !== 4'd0)   begin n_bad++; $display("FAIL midrst level: got %0d expected 0", level); end
        n_cmp++; if (ovf !== 1'b0)     begin n_bad++; $display("FAIL midrst ovf: got %0b expected 0", ovf); end
        step();
        step();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL post-rst tx_busy: got %0b expected 0", tx_busy); end
        n_cmp++; if (level !== 4'd0)   begin n_bad++; $display("FAIL post-rst level: got %0d expected 0", level); end
        n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL post-rst empty: got %0b expected 1", empty); end
        prescale = 16'd1;
        push_byte(8'h3C);
        n_cmp++; if (txd !== 1'b1)     begin n_bad++; $display("FAIL post-rst push-edge txd: got %0b expected 1", txd); end
        step();
        expect_frame("frame3C", 8'h3C, 8);
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL post-rst end tx_busy: got %0b expected 0", tx_busy); end
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_prescale_change();
        prescale = 16'd1;
        push_byte(8'h33);
        push_byte(8'hC5);
        prescale = 16'd4;
        expect_frame("frame33", 8'h33, 8);
        step();
        expect_frame("frameC5", 8'hC5, 32);
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL prescale end tx_busy: got %0b expected 0", tx_busy); end
        prescale = 16'd0;
        push_byte(8'h5A);
        step();
        expect_frame("frame5A_ps0", 8'h5A, 8);
        step();
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL ps0 end tx_busy: got %0b expected 0", tx_busy); end
        $display("test_prescale_change done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_prescale_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
